uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal transmit FIFO, configurable data-bit count, runtime parity mode and runtime 1/2 stop bits. Accepts bytes (words) through a valid/ready handshake and serialises them back-to-back with no idle gap while data is queued. Driven by the shared baud generator's tx_tick (one pulse per bit period). Sits between the host register/bus interface and the tx pad.

Parameters:
DATA_BITS, 8, frame data width; legal 5..9, elaboration error otherwise
FIFO_DEPTH, 16, FIFO entries; power of two, >=2
CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count (derived, do not override)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tx_tick  in  1  baud tick, single-cycle pulse per bit period
in_valid  in  1  host word valid
in_ready  out  1  FIFO can accept (= not full)
in_data  in  DATA_BITS  word to transmit, LSB sent first
cfg_parity  in  2  parity_e: PAR_NONE / PAR_EVEN / PAR_ODD
cfg_two_stop  in  1  1 = two stop bits
tx  out  1  serial line, idle high
tx_busy  out  1  frame in progress
tx_done  out  1  one-cycle pulse at end of each frame's last stop bit
fifo_count  out  CNT_W  words queued (excludes word being shifted)

Behaviour:
- Reset (async): tx=1, tx_busy=0, tx_done=0, fifo_count=0, FIFO emptied, state IDLE, shift/bit counters 0. Reset mid-frame aborts immediately; line returns high with no stop bit.
- FIFO push when in_valid && in_ready. in_ready=0 when count==FIFO_DEPTH; push while full is ignored, even if a pop occurs the same cycle. Pop only when registered count>0 (no fall-through: word pushed into an empty FIFO is popped no earlier than next cycle). Simultaneous push+pop: count unchanged.
- All tx transitions occur on the clk edge at which tx_tick=1; tx is registered; each bit lasts exactly one tick interval.
- States: IDLE, START, DATA, PARITY, STOP.
  IDLE: tx=1. On tick with count>0: pop into shift reg, latch cfg_parity/cfg_two_stop, tx<=0, tx_busy<=1 -> START.
  START: on tick: tx<=bit0, bit_cnt<=0 -> DATA.
  DATA: on tick: if bit_cnt==DATA_BITS-1 -> PARITY (tx<=parity bit) when latched mode != PAR_NONE, else STOP (tx<=1); otherwise tx<=next bit, bit_cnt++.
  PARITY: on tick: tx<=1, stop_cnt<=0 -> STOP.
  STOP: on tick: if two_stop && stop_cnt==0 -> stop_cnt++, stay (tx=1). Else tx_done<=1 for one cycle; if count>0, pop and start next frame (tx<=0 -> START, tx_busy stays 1); else tx_busy<=0 -> IDLE.
- Parity computed over the DATA_BITS of the latched word: even = XOR reduction, odd = inverted XOR. cfg changes mid-frame have no effect until the next frame start.
- Frame length in ticks: 1 + DATA_BITS + (parity?1:0) + (two_stop?2:1).
- cfg_parity = 2'b11 treated as PAR_NONE.

Optional Feature:
UART_TX_BREAK_EN: adds input tx_break (1). Defined: tx_break sampled only at frame boundaries (IDLE tick or final STOP tick); when high, FIFO is not popped, tx<=0, tx_busy=1, state BREAK; held until a tick with tx_break=0, then tx<=1 for one full tick interval (mark) before returning to IDLE/next frame. No tx_done for a break. Undefined: port absent, BREAK state absent; behaviour exactly as above.

Decomposition:
- Package uart_pkg: parity_e enum (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2), tx_state_e enum (IDLE, START, DATA, PARITY, STOP, BREAK), constants DATA_BITS_MIN=5, DATA_BITS_MAX=9.
- Sub-module uart_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count; async active-high reset), reusable by the receiver.

Test Plan:
- DATA_BITS=8, no parity, 1 stop, push 0xA5 -> tx after ticks: 0,1,0,1,0,0,1,0,1,1 (10 ticks); tx_done pulses once; tx_busy drops same edge as tx_done.
- Even parity, push 0x07 -> parity bit 1; odd parity, push 0x07 -> parity 0; frame 11 ticks.
- cfg_two_stop=1, push 0x00 and 0xFF in consecutive cycles -> two frames back-to-back, 11 ticks each, two stop-high ticks between them, tx_busy never low between frames.
- Fill FIFO with 17 pushes while no ticks -> in_ready low after 16th, 17th ignored, fifo_count=16; drain -> 16 frames in push order.
- Assert reset mid-DATA of 0x3C -> tx=1 and tx_busy=0 without a clk edge; fifo_count=0; after release next push transmits cleanly.
- (UART_TX_BREAK_EN) tx_break high for 5 ticks while idle -> tx low 5 ticks, then 1 tick high, then queued word 0x55 sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and limits: parity modes, transmitter states and the
// legal data-width range.
package uart_pkg;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } tx_state_e;

    // Encoding 2'b11 is reserved and behaves like PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with head-of-queue read data; shared by the UART
// transmitter and receiver.
module uart_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    // A push while full is dropped even if a pop frees a slot the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with transmit FIFO, runtime parity and 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the tx_break input and BREAK state.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_BITS  = 8,
    parameter  int FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_tick,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                 tx_break,
`endif
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic [CNT_W-1:0]     fifo_count
);

    generate
        if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
            $error("uart_tx_fifo: DATA_BITS must be within 5..9");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 two_stop_q, two_stop_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef UART_TX_BREAK_EN
    logic                 mark_q, mark_d;
`endif

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 boundary;
    logic                 launch;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fifo_pop   = 1'b0;
        boundary   = 1'b0;
        launch     = 1'b0;
`ifdef UART_TX_BREAK_EN
        mark_d     = mark_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d     = 1'b1;
                busy_d   = 1'b0;
                boundary = tx_tick;
            end
            START: if (tx_tick) begin
                tx_d      = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_cnt_d = '0;
                state_d   = DATA;
            end
            DATA: if (tx_tick) begin
                if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                    stop_cnt_d = 1'b0;
                    tx_d       = par_en_q ? par_bit_q : 1'b1;
                    state_d    = par_en_q ? PARITY : STOP;
                end else begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            PARITY: if (tx_tick) begin
                tx_d       = 1'b1;
                stop_cnt_d = 1'b0;
                state_d    = STOP;
            end
            STOP: if (tx_tick) begin
                if (two_stop_q && !stop_cnt_q) begin
                    stop_cnt_d = 1'b1;
                end else begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                    boundary = 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            // Hold the line low until tx_break drops, then one mark tick.
            BREAK: if (tx_tick) begin
                if (!mark_q) begin
                    if (!tx_break) begin
                        tx_d   = 1'b1;
                        mark_d = 1'b1;
                    end
                end else begin
                    mark_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    launch  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

`ifdef UART_TX_BREAK_EN
        if (boundary && tx_break) begin
            state_d = BREAK;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            mark_d  = 1'b0;
        end else
`endif
        if ((boundary || launch) && !fifo_empty) begin
            // Frame start: config and parity are frozen here for the whole frame.
            fifo_pop   = 1'b1;
            shift_d    = fifo_rd_data;
            par_en_d   = parity_enabled(cfg_parity);
            par_bit_d  = (^fifo_rd_data) ^ (cfg_parity == PAR_ODD);
            two_stop_d = cfg_two_stop;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
            state_d    = START;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef UART_TX_BREAK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mark_q <= 1'b0;
        else       mark_q <= mark_d;
    end
`endif

    assign in_ready = !fifo_full;
    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed frames pinned to literal waveforms, then
// randomized traffic checked every cycle against a frame-level queue model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       reset;
    logic       tx_tick = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [1:0] cfg_parity = 2'd0;
    logic       cfg_two_stop = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic [4:0] fifo_count;
`ifdef UART_TX_BREAK_EN
    logic       tx_break = 1'b0;
`endif

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_tick      (tx_tick),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .cfg_parity   (cfg_parity),
        .cfg_two_stop (cfg_two_stop),
`ifdef UART_TX_BREAK_EN
        .tx_break     (tx_break),
`endif
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .fifo_count   (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_pass = 0;
    int n_fail_lines = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else begin
            if (n_fail_lines < 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
            n_fail_lines++;
        end
    endtask

    // Frame-level model: a word queue plus the list of line bits still owed.
    logic [7:0] mq[$];
    bit         fb[$];
    bit         m_in_frame = 1'b0;
    bit         e_tx = 1'b1;
    bit         e_done = 1'b0;
    bit         tick_at_edge = 1'b0;
    int         frame_no = 0;
    logic [7:0] cur_word = 8'h00;
    int         cur_par = 0;
    bit         cur_two = 1'b0;
    bit         cmp_en = 1'b0;

    initial begin
        int  pre;
        bit  pushv;
        int  ones;
        forever begin
            @(posedge clk);
            tick_at_edge = tx_tick;
            if (reset) begin
                mq.delete();
                fb.delete();
                m_in_frame = 1'b0;
                e_tx = 1'b1;
                e_done = 1'b0;
            end else begin
                pre = mq.size();
                pushv = in_valid && (pre < DEPTH);
                e_done = 1'b0;
                if (tx_tick) begin
                    if (m_in_frame) begin
                        if (fb.size() > 0) e_tx = fb.pop_front();
                        else begin
                            e_done = 1'b1;
                            e_tx = 1'b1;
                            m_in_frame = 1'b0;
                            frame_no++;
                            $display("frame %0d word=0x%02h parity=%0d two_stop=%0d",
                                     frame_no, cur_word, cur_par, cur_two);
                        end
                    end
                    if (!m_in_frame && pre > 0) begin
                        cur_word = mq.pop_front();
                        cur_par = int'(cfg_parity);
                        cur_two = cfg_two_stop;
                        fb.push_back(1'b0);
                        for (int i = 0; i < 8; i++) fb.push_back(cur_word[i]);
                        ones = $countones(cur_word);
                        if (cur_par == 1) fb.push_back((ones % 2) == 1);
                        if (cur_par == 2) fb.push_back((ones % 2) == 0);
                        fb.push_back(1'b1);
                        if (cur_two) fb.push_back(1'b1);
                        e_tx = fb.pop_front();
                        m_in_frame = 1'b1;
                    end
                end
                if (pushv) mq.push_back(in_data);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && cmp_en) begin
                chk("tx", int'(tx), int'(e_tx));
                chk("tx_busy", int'(tx_busy), int'(m_in_frame));
                chk("tx_done", int'(tx_done), int'(e_done));
                chk("fifo_count", int'(fifo_count), mq.size());
                chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
            end
        end
    end

    // Per-tick capture of the line, starting once a frame is under way.
    bit cap_on = 1'b0;
    bit cap_started = 1'b0;
    bit cap_tx[$];
    bit cap_done[$];
    bit cap_busy[$];
    int done_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && tx_done) done_cnt++;
            if (!reset && cap_on && tick_at_edge) begin
                if (tx_busy) cap_started = 1'b1;
                if (cap_started) begin
                    cap_tx.push_back(tx);
                    cap_done.push_back(tx_done);
                    cap_busy.push_back(tx_busy);
                end
            end
        end
    end

    bit tick_en = 1'b0;
    bit tick_rand = 1'b0;
    int tick_div = 3;
    int tick_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (tick_rand) tx_tick = ($urandom_range(2) == 0);
            else if (tick_en) begin
                if (tick_cnt >= tick_div - 1) begin
                    tx_tick = 1'b1;
                    tick_cnt = 0;
                end else begin
                    tx_tick = 1'b0;
                    tick_cnt++;
                end
            end else tx_tick = 1'b0;
        end
    end

    task automatic start_cap();
        cap_tx.delete();
        cap_done.delete();
        cap_busy.delete();
        cap_started = 1'b0;
        cap_on = 1'b1;
    endtask

    task automatic wait_cap(input int n, input string name);
        int g;
        g = 0;
        while (cap_tx.size() < n && g < 4000) begin
            @(negedge clk);
            g++;
        end
        if (cap_tx.size() < n) chk({name, "_timeout"}, cap_tx.size(), n);
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while ((mq.size() > 0 || m_in_frame) && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (mq.size() > 0 || m_in_frame) chk({name, "_idle_timeout"}, mq.size(), 0);
    endtask

    task automatic push_word(input logic [7:0] w);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic int cap_vec10();
        logic [9:0] v;
        v = '0;
        for (int i = 0; i < 10 && i < cap_tx.size(); i++) v[i] = cap_tx[i];
        return int'(v);
    endfunction

    initial begin
        int n;
        bit all_busy;
        reset = 1'b0;
        #2 reset = 1'b1;
        #2;
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(tx_busy), 0);
        chk("reset_done", int'(tx_done), 0);
        chk("reset_count", int'(fifo_count), 0);
        chk("reset_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;

        // 0xA5, 8N1
        tick_en = 1'b1;
        tick_div = 3;
        start_cap();
        push_word(8'hA5);
        wait_cap(11, "a5");
        chk("a5_bits", cap_vec10(), int'(10'b1101001010));
        chk("a5_done_end", int'(cap_done[10]), 1);
        chk("a5_busy_end", int'(cap_busy[10]), 0);
        n = 0;
        for (int i = 0; i < 11; i++) n += int'(cap_done[i]);
        chk("a5_done_pulses", n, 1);
        cap_on = 1'b0;
        wait_idle("a5");

        // 0x07 with even then odd parity
        for (int p = 1; p <= 2; p++) begin
            cfg_parity = 2'(p);
            start_cap();
            push_word(8'h07);
            wait_cap(12, "par");
            chk(p == 1 ? "even_parity_bit" : "odd_parity_bit", int'(cap_tx[9]), p == 1 ? 1 : 0);
            chk("par_stop_bit", int'(cap_tx[10]), 1);
            chk("par_done_not_early", int'(cap_done[10]), 0);
            chk("par_done_at_11", int'(cap_done[11]), 1);
            cap_on = 1'b0;
            wait_idle("par");
        end

        // Two stop bits, 0x00 then 0xFF back-to-back
        cfg_parity = 2'd0;
        cfg_two_stop = 1'b1;
        start_cap();
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'h00;
        @(negedge clk);
        in_data = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cap(23, "two_stop");
        chk("two_stop_first", int'(cap_tx[9]), 1);
        chk("two_stop_second", int'(cap_tx[10]), 1);
        chk("two_stop_next_start", int'(cap_tx[11]), 0);
        chk("two_stop_done1", int'(cap_done[11]), 1);
        chk("two_stop_ff_bit0", int'(cap_tx[12]), 1);
        chk("two_stop_done2", int'(cap_done[22]), 1);
        chk("two_stop_busy_end", int'(cap_busy[22]), 0);
        all_busy = 1'b1;
        for (int i = 0; i < 22; i++) all_busy &= cap_busy[i];
        chk("two_stop_busy_held", int'(all_busy), 1);
        cap_on = 1'b0;
        wait_idle("two_stop");
        cfg_two_stop = 1'b0;

        // Fill with 17 pushes while no ticks, then drain
        tick_en = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 15) chk("fill_ready_at_15", int'(in_ready), 1);
            if (i == 16) chk("fill_ready_at_16", int'(in_ready), 0);
            in_valid = 1'b1;
            in_data = 8'(8'h80 + i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("fill_count", int'(fifo_count), 16);
        chk("fill_ready", int'(in_ready), 0);
        done_cnt = 0;
        tick_div = 1;
        tick_en = 1'b1;
        wait_idle("drain");
        repeat (2) @(negedge clk);
        chk("drain_frames", done_cnt, 16);
        chk("drain_count", int'(fifo_count), 0);

        // Reset in the middle of the data bits of 0x3C
        tick_div = 2;
        start_cap();
        push_word(8'h3C);
        push_word(8'h11);
        wait_cap(2, "mid_reset");
        chk("pre_reset_tx", int'(tx), 0);
        #1 reset = 1'b1;
        #1;
        chk("mid_reset_tx", int'(tx), 1);
        chk("mid_reset_busy", int'(tx_busy), 0);
        chk("mid_reset_count", int'(fifo_count), 0);
        cap_on = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start_cap();
        push_word(8'h5A);
        wait_cap(11, "after_reset");
        chk("after_reset_bits", cap_vec10(), int'(10'b1010110100));
        chk("after_reset_done", int'(cap_done[10]), 1);
        cap_on = 1'b0;
        wait_idle("after_reset");

        // Randomized traffic with random ticks and config changes
        tick_en = 1'b0;
        tick_rand = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            in_valid = ($urandom_range(3) == 0);
            in_data = 8'($urandom);
            cfg_parity = 2'($urandom_range(3));
            cfg_two_stop = 1'($urandom_range(1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle("random");
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
